// File: rtl/uart_pkg.sv
// Shared UART definitions: parity and TX state encodings plus frame-format helpers.
package uart_pkg;

  localparam int unsigned MIN_DATA_BITS = 5;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } tx_state_e;

  function automatic logic [3:0] clamp_bits(logic [3:0] req, logic [3:0] max_bits);
    if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (req > max_bits) return max_bits;
    return req;
  endfunction

  // The raw encoding 2'b11 also means no parity.
  function automatic parity_e decode_parity(logic [1:0] raw);
    case (raw)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; full/empty derive from the level, not the pointers.
module uart_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with TX FIFO, runtime frame format (5-9 data bits, parity, 1/2 stop)
// and line break. tx_o and done_o are registered, so both lag the FSM state by one clock.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 9,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [DIV_W-1:0]              bauddiv_i,
  input  logic [3:0]                    data_bits_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  input  logic                          break_i,
  input  logic                          wr_valid_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic                          wr_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          tx_o,
  output logic                          tx_busy_o,
  output logic                          done_o
);

  tx_state_e          state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [3:0]         bitcnt_q, bitcnt_d;
  logic [3:0]         nbits_q, nbits_d;
  parity_e            par_q, par_d;
  logic               stop2_q, stop2_d;
  logic               acc_q, acc_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W-1:0]  fifo_rdata;
  logic               bit_end, can_start, start_frame;

  uart_sync_fifo #(
    .Width (DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .push_i  (wr_valid_i),
    .wdata_i (wr_data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign wr_ready_o = !fifo_full;
  assign tx_busy_o  = (state_q != StIdle) || !fifo_empty;
  assign tx_o       = tx_q;
  assign done_o     = done_q;
  assign bit_end    = (cnt_q == '0);
  assign can_start  = !fifo_empty && !break_i;
  assign fifo_pop   = start_frame;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    nbits_d     = nbits_q;
    par_d       = par_q;
    stop2_d     = stop2_q;
    acc_d       = acc_q;
    tx_d        = 1'b1;
    done_d      = 1'b0;
    start_frame = 1'b0;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? bauddiv_i : cnt_q - DIV_W'(1);
    end

    case (state_q)
      StIdle: begin
        tx_d        = !break_i;
        start_frame = can_start;
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d  = StData;
          bitcnt_d = '0;
          acc_d    = 1'b0;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d  = shift_q >> 1;
          acc_d    = acc_q ^ shift_q[0];
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == nbits_q - 4'd1) begin
            state_d = (par_q != PAR_NONE) ? StParity : StStop1;
          end
        end
      end
      StParity: begin
        tx_d = acc_q ^ (par_q == PAR_ODD);
        if (bit_end) state_d = StStop1;
      end
      StStop1: begin
        if (bit_end) begin
          if (stop2_q) begin
            state_d = StStop2;
          end else begin
            done_d      = 1'b1;
            start_frame = can_start;
            state_d     = StIdle;
          end
        end
      end
      StStop2: begin
        if (bit_end) begin
          done_d      = 1'b1;
          start_frame = can_start;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Frame format is captured together with the popped word and held for the whole frame.
    if (start_frame) begin
      state_d = StStart;
      cnt_d   = bauddiv_i;
      shift_d = fifo_rdata;
      nbits_d = clamp_bits(data_bits_i, 4'(DATA_W));
      par_d   = decode_parity(parity_i);
      stop2_d = stop2_i;
      acc_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      nbits_q  <= 4'(MIN_DATA_BITS);
      par_q    <= PAR_NONE;
      stop2_q  <= 1'b0;
      acc_q    <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      nbits_q  <= nbits_d;
      par_q    <= par_d;
      stop2_q  <= stop2_d;
      acc_q    <= acc_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: expected frames are queued on push and checked bit by bit.
module tb_uart_tx_cfg;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic [15:0] bauddiv;
  logic [3:0]  data_bits;
  logic [1:0]  parity;
  logic        stop2;
  logic        brk;
  logic        wr_valid;
  logic [8:0]  wr_data;
  logic        wr_ready;
  logic [3:0]  level;
  logic        tx_o;
  logic        busy;
  logic        done_o;

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          n_done    = 0;
  int          bdiv      = 4;
  int          cur_nb    = 8;
  int          cur_par   = 0;
  bit          cur_s2    = 1'b0;
  bit          mon_en    = 1'b1;
  frame_t      sb[$];

  uart_tx_cfg #(
    .DATA_W     (9),
    .FIFO_DEPTH (8),
    .DIV_W      (16)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .bauddiv_i    (bauddiv),
    .data_bits_i  (data_bits),
    .parity_i     (parity),
    .stop2_i      (stop2),
    .break_i      (brk),
    .wr_valid_i   (wr_valid),
    .wr_data_i    (wr_data),
    .wr_ready_o   (wr_ready),
    .fifo_level_o (level),
    .tx_o         (tx_o),
    .tx_busy_o    (busy),
    .done_o       (done_o)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (done_o === 1'b1) n_done++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t model(input logic [8:0] d, input int nb_req, input int par,
                                   input bit s2);
    frame_t f;
    int     nb;
    int     idx;
    logic   x;
    nb = (nb_req < 5) ? 5 : (nb_req > 9) ? 9 : nb_req;
    f.bits = '0;
    idx = 1;
    x = 1'b0;
    for (int i = 0; i < nb; i++) begin
      f.bits[idx] = d[i];
      x = x ^ d[i];
      idx++;
    end
    if (par == 1) begin f.bits[idx] = x;  idx++; end
    if (par == 2) begin f.bits[idx] = ~x; idx++; end
    f.bits[idx] = 1'b1;
    idx++;
    if (s2) begin f.bits[idx] = 1'b1; idx++; end
    f.len = idx;
    return f;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cfg(input int div_m1, input int nb, input int par, input bit s2);
    bauddiv = 16'(div_m1);
    data_bits = 4'(nb);
    parity = 2'(par);
    stop2 = s2;
    bdiv = div_m1 + 1;
    cur_nb = nb;
    cur_par = par;
    cur_s2 = s2;
  endtask

  task automatic push(input logic [8:0] d, input bit expected);
    wr_data = d;
    wr_valid = 1'b1;
    if (expected) sb.push_back(model(d, cur_nb, cur_par, cur_s2));
    cyc(1);
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n, input int bound);
    int k = 0;
    int c = 0;
    while (k < n && c < bound) begin
      @(negedge clock);
      c++;
      if (done_o === 1'b1) k++;
    end
    check(tag, k, n);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int c = 0;
    while (busy !== 1'b0 && c < bound) begin
      @(negedge clock);
      c++;
    end
    check(tag, busy, 0);
  endtask

  // Frame monitor: a falling edge outside break starts a frame; sample each bit mid-period.
  initial begin : monitor
    logic   prev;
    frame_t f;
    int     off;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (mon_en && prev === 1'b1 && tx_o === 1'b0 && brk === 1'b0) begin
        check("frame_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          f = sb.pop_front();
          off = 0;
          for (int i = 0; i < f.len; i++) begin
            while (off < i * bdiv + bdiv / 2) begin
              @(negedge clock);
              off++;
            end
            check($sformatf("frame_bit%0d", i), tx_o, f.bits[i]);
          end
          while (off < f.len * bdiv - 1) begin
            @(negedge clock);
            off++;
          end
          check("done_at_last_stop", done_o, 1);
        end
      end
      prev = tx_o;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int d0;
    int k;
    int c;
    resetn = 1'b0;
    brk = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    cfg(3, 8, 0, 1'b0);
    #12;
    check("rst_tx", tx_o, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done_o, 0);
    check("rst_level", level, 0);
    check("rst_ready", wr_ready, 1);
    cyc(1);
    resetn = 1'b1;
    cyc(2);

    // 8N1, 0x55: latency from push to start bit, then the full frame.
    d0 = n_done;
    push(9'h055, 1'b1);
    @(negedge clock);
    check("t1_level_after_push", level, 1);
    check("t1_tx_idle_n", tx_o, 1);
    @(negedge clock);
    check("t1_level_after_pop", level, 0);
    check("t1_busy", busy, 1);
    check("t1_tx_idle_n1", tx_o, 1);
    @(negedge clock);
    check("t1_tx_start_n2", tx_o, 0);
    wait_done("t1_done", 1, 200);
    wait_idle("t1_idle", 20);
    cyc(5);
    check("t1_single_done", n_done, d0 + 1);

    // 7E2 and 9O1, then clamped widths.
    cfg(2, 7, 1, 1'b1);
    push(9'h003, 1'b1);
    wait_done("t2_done", 1, 200);
    wait_idle("t2_idle", 20);
    cyc(2);
    cfg(2, 9, 2, 1'b0);
    push(9'h1ff, 1'b1);
    wait_done("t3_done", 1, 200);
    wait_idle("t3_idle", 20);
    cyc(2);
    cfg(1, 2, 1, 1'b0);
    push(9'h1f3, 1'b1);
    wait_done("t3_clamp_lo", 1, 200);
    wait_idle("t3_idle_lo", 20);
    cyc(2);
    cfg(1, 15, 0, 1'b0);
    push(9'h155, 1'b1);
    wait_done("t3_clamp_hi", 1, 200);
    wait_idle("t3_idle_hi", 20);
    cyc(2);

    // Fill the FIFO under break, overflow once, then drain back-to-back.
    cfg(1, 8, 0, 1'b0);
    brk = 1'b1;
    cyc(3);
    check("t4_break_idle_tx", tx_o, 0);
    for (int i = 0; i < 8; i++) push(9'($urandom_range(0, 255)), 1'b1);
    wr_data = 9'h0aa;
    wr_valid = 1'b1;
    check("t4_full_ready", wr_ready, 0);
    check("t4_full_level", level, 8);
    cyc(1);
    wr_valid = 1'b0;
    @(negedge clock);
    check("t4_level_after_drop", level, 8);
    check("t4_tx_held_low", tx_o, 0);
    cyc(1);
    brk = 1'b0;
    @(posedge clock);
    k = 0;
    c = 0;
    while (k < 8 && c < 1000) begin
      @(negedge clock);
      c++;
      if (done_o === 1'b1) k++;
    end
    check("t4_done_count", k, 8);
    check("t4_b2b_cycles", c, 8 * 10 * 2 + 1);
    wait_idle("t4_idle", 20);
    cyc(2);

    // Break raised mid-frame: current frame finishes, next waits for release.
    cfg(3, 8, 0, 1'b0);
    push(9'h00f, 1'b1);
    push(9'h0f0, 1'b1);
    cyc(12);
    brk = 1'b1;
    wait_done("t5_first_done", 1, 200);
    cyc(3);
    check("t5_break_tx", tx_o, 0);
    check("t5_busy", busy, 1);
    check("t5_level", level, 1);
    cyc(10);
    check("t5_break_tx_hold", tx_o, 0);
    brk = 1'b0;
    wait_done("t5_second_done", 1, 200);
    wait_idle("t5_idle", 20);
    cyc(2);

    // Asynchronous reset in the middle of a data bit.
    mon_en = 1'b0;
    d0 = n_done;
    push(9'h0a5, 1'b0);
    push(9'h03c, 1'b0);
    check("t6_push_pop_level", level, 1);
    cyc(6);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_tx", tx_o, 1);
    check("t6_rst_level", level, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", wr_ready, 1);
    cyc(3);
    resetn = 1'b1;
    cyc(20);
    check("t6_no_done", n_done, d0);
    check("t6_tx_idle", tx_o, 1);
    check("t6_busy_idle", busy, 0);
    mon_en = 1'b1;

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter with a built-in transmit FIFO, runtime-selectable frame format (5–9 data bits, none/even/odd parity, 1 or 2 stop bits) and line-break generation. It is the next-generation TX engine for the TileLink UART peripheral. The register front-end pushes bytes through a valid/ready port, so software no longer has to pace single-byte transfers.

## Interface
Parameters:
- DATA_W, 9, maximum data bits per frame (5..9)
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥2
- DIV_W, 16, baud divider width

Ports:
- clock  in  1  sole clock
- resetn  in  1  asynchronous, active-low reset
- bauddiv_i  in  DIV_W  bit period minus one, in clocks; sampled per bit period
- data_bits_i  in  4  data bits per frame; <5 treated as 5, >DATA_W treated as DATA_W
- parity_i  in  2  00 none, 01 even, 10 odd, 11 none
- stop2_i  in  1  1 = two stop bits
- break_i  in  1  hold line low while engine idle
- wr_valid_i  in  1  push request
- wr_data_i  in  DATA_W  frame data, LSB first on the line
- wr_ready_o  out  1  FIFO not full
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  entries held
- tx_o  out  1  serial line, idle high
- tx_busy_o  out  1  frame in progress or FIFO non-empty
- done_o  out  1  one-cycle pulse at end of each frame

## Operation
- Reset values: tx_o=1, tx_busy_o=0, done_o=0, fifo_level_o=0, wr_ready_o=1. Any frame or FIFO contents are discarded asynchronously.
- Push: accepted on a clock edge when wr_valid_i && wr_ready_o. Push while full is ignored, and the data is dropped.
- There is no bypass path. When full, wr_ready_o stays 0 even in a cycle where a pop occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE → START: when FIFO is non-empty and break_i=0. The head entry is popped on this transition.
  - data_bits_i, parity_i and stop2_i are latched at this point and are stable for the whole frame.
- Each state other than IDLE lasts bauddiv_i+1 clocks. A down-counter is loaded with bauddiv_i on entry and the state advances when the count reaches 0.
- START: drives 0.
- DATA: drives shift[0] for each bit; the shifter moves right after each bit. Exits after the latched number of data bits.
- PARITY: entered only when parity is enabled.
  - Even: the bit is the XOR of the transmitted data bits. Odd: the inverted XOR.
  - Data bits above the latched count are ignored.
- STOP1 and STOP2: drive 1. STOP2 is entered only if stop2 is latched.
- End of the last stop bit: done_o pulses for 1 cycle.
  - If the FIFO is non-empty and break_i=0, go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- break_i: while in IDLE, tx_o=0. Asserting break_i mid-frame has no effect until the frame completes, and no new frame starts while break_i=1.
- tx_o is registered and glitch-free.

## Timing
- With engine IDLE and FIFO empty, a push accepted at edge n:
  - level=1 after edge n
  - pop and START at edge n+1
  - tx_o=0 from edge n+2
- Frame length in bits = 1 + data_bits + parity_en + 1 + stop2. Each bit is bauddiv_i+1 clocks.
- done_o is asserted in the same cycle that tx_o completes its final stop bit.
- fifo_level_o updates one cycle after a push or pop edge. Simultaneous push and pop when not full leaves the level unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished using level, not pointer equality.

## Structure
- Shared package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD)
  - tx_state_e enum
  - constant MIN_DATA_BITS=5
- Sub-module uart_sync_fifo: parametrised width and depth, with push/pop/level ports. It is intended for reuse by the future RX block.
- The engine FSM, counter and shifter live in uart_tx_cfg.

## Test plan
- 8N1, bauddiv=3, push 0x55 → tx_o: 0,1,0,1,0,1,0,1,0,1, 4 clocks per bit, falling 2 cycles after push; done_o pulses once.
- 7E2, push 0x03 → 7 data bits 1,1,0,0,0,0,0, parity 0, two stop bits; frame = 11 bit periods.
- 9-bit odd parity, push 0x1FF → parity bit 0; bit 8 = 1 on the line.
- Push 9 words with FIFO_DEPTH=8 and the engine stalled by break_i=1 → 9th push refused (wr_ready_o=0, level=8). Release break → 8 frames back-to-back with no idle gap; 8 done_o pulses.
- break_i=1 mid-frame → frame completes normally, then tx_o=0 until release; next queued frame starts after release.
- Assert resetn=0 mid DATA bit → tx_o=1, level=0 and busy=0 immediately (asynchronously); no done_o pulse.
